// File: rtl/vga_frame_grabber.sv
// vga_frame_grabber: captures an active-video pixel stream into a one- or
// two-bank frame store. It checks line and frame geometry against the
// configured resolution and provides a registered read port together with
// frame and error status.

`ifndef SCREEN_W
`define SCREEN_W 640
`endif
`ifndef SCREEN_H
`define SCREEN_H 480
`endif

module vga_frame_grabber #(
    parameter int SCR_W      = `SCREEN_W,
    parameter int SCR_H      = `SCREEN_H,
    parameter int PIX_FMT    = 0,
    parameter int VS_POL     = 1,
    parameter int DOUBLE_BUF = 1,
    parameter int AW         = $clog2(SCR_W * SCR_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs_i,
    input  logic          hs_i,
    input  logic          de_i,
    input  logic [7:0]    data_r_i,
    input  logic [7:0]    data_g_i,
    input  logic [7:0]    data_b_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    output logic          frame_done_o,
    output logic [15:0]   frame_cnt_o,
    output logic          err_line_o,
    output logic          err_frame_o,
    output logic          wr_bank_o,
    output logic          rd_bank_o
);

    localparam int DEPTH = SCR_W * SCR_H;
    localparam int NB    = (DOUBLE_BUF != 0) ? 2 : 1;
    localparam int MW    = $clog2(NB * DEPTH);
    localparam int XW    = $clog2(SCR_W + 1);
    localparam int YW    = $clog2(SCR_H + 1);

    localparam logic [XW-1:0] X_MAX       = XW'(SCR_W);
    localparam logic [YW-1:0] Y_MAX       = YW'(SCR_H);
    localparam logic [YW-1:0] Y_LAST      = YW'(SCR_H - 1);
    localparam logic          RD_BANK_RST = (DOUBLE_BUF != 0);

    // hsync is only observed on the bus; counting relies on de alone
    logic unused_hs;
    assign unused_hs = hs_i;

    // Frame store, banks laid out back to back
    logic [31:0] mem_q [NB*DEPTH];

    // Input sampling and edge detection
    logic vs_act;
    logic vs_r_q;
    logic de_r_q;
    logic vs_rise;

    // Geometry tracking
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic line_bad_q,   line_bad_d;
    logic frame_bad_q,  frame_bad_d;
    logic frame_seen_q, frame_seen_d;
    logic done_q,       done_d;

    // Events detected this edge, presented on the outputs one edge later
    logic ev_done_q,  ev_done_d;
    logic ev_line_q,  ev_line_d;
    logic ev_frame_q, ev_frame_d;

    logic        frame_done_q;
    logic        err_line_q;
    logic        err_frame_q;
    logic [15:0] frame_cnt_q;
    logic        wr_bank_q;
    logic        rd_bank_q;
    logic [31:0] rd_data_q;

    logic          bad_line;
    logic          wr_en;
    logic [MW-1:0] wr_idx;
    logic [31:0]   pix_word;
    logic [15:0]   luma_sum;
    logic [7:0]    luma;
    logic [4:0]    r5;
    logic [5:0]    g6;
    logic [4:0]    b5;
    logic          rd_in_range;
    logic [MW-1:0] rd_idx;

    assign vs_act  = (VS_POL != 0) ? vs_i : ~vs_i;
    assign vs_rise = vs_act & ~vs_r_q;

    // Pixel format conversion into the 32-bit stored word
    always_comb begin
        r5       = data_r_i[7:3];
        g6       = data_g_i[7:2];
        b5       = data_b_i[7:3];
        luma_sum = 16'd77  * {8'd0, data_r_i}
                 + 16'd150 * {8'd0, data_g_i}
                 + 16'd29  * {8'd0, data_b_i};
        luma     = 8'(luma_sum >> 8);
        case (PIX_FMT)
            1:       pix_word = {8'd0, r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
            2:       pix_word = {8'd0, luma, luma, luma};
            default: pix_word = {8'd0, data_r_i, data_g_i, data_b_i};
        endcase
    end

    // Next-state for counters, flags and event strobes; vs_rise wins
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        line_bad_d   = line_bad_q;
        frame_bad_d  = frame_bad_q;
        frame_seen_d = frame_seen_q;
        done_d       = done_q;
        ev_done_d    = 1'b0;
        ev_line_d    = 1'b0;
        ev_frame_d   = 1'b0;
        wr_en        = 1'b0;
        bad_line     = 1'b0;
        if (vs_rise) begin
            ev_frame_d   = frame_seen_q & ~done_q;
            x_d          = '0;
            y_d          = '0;
            line_bad_d   = 1'b0;
            frame_bad_d  = 1'b0;
            frame_seen_d = 1'b0;
            done_d       = 1'b0;
        end else if (de_i) begin
            frame_seen_d = 1'b1;
            if ((x_q < X_MAX) && (y_q < Y_MAX)) begin
                wr_en = 1'b1;
            end else begin
                line_bad_d = 1'b1;
            end
            if (x_q < X_MAX) begin
                x_d = x_q + 1'b1;
            end
        end else if (de_r_q) begin
            bad_line    = (x_q != X_MAX) || line_bad_q || (y_q >= Y_MAX);
            ev_line_d   = bad_line;
            frame_bad_d = frame_bad_q | bad_line;
            x_d         = '0;
            line_bad_d  = 1'b0;
            if (y_q < Y_MAX) begin
                y_d = y_q + 1'b1;
            end
            if ((y_q == Y_LAST) && !bad_line && !frame_bad_q && !done_q) begin
                ev_done_d = 1'b1;
                done_d    = 1'b1;
            end
        end
    end

    assign wr_idx = MW'(int'(wr_bank_q) * DEPTH + int'(y_q) * SCR_W + int'(x_q));

    // Capture state, status outputs and bank bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_r_q       <= 1'b0;
            de_r_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            line_bad_q   <= 1'b0;
            frame_bad_q  <= 1'b0;
            frame_seen_q <= 1'b0;
            done_q       <= 1'b0;
            ev_done_q    <= 1'b0;
            ev_line_q    <= 1'b0;
            ev_frame_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            frame_cnt_q  <= 16'd0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= RD_BANK_RST;
        end else begin
            vs_r_q       <= vs_act;
            de_r_q       <= de_i;
            x_q          <= x_d;
            y_q          <= y_d;
            line_bad_q   <= line_bad_d;
            frame_bad_q  <= frame_bad_d;
            frame_seen_q <= frame_seen_d;
            done_q       <= done_d;
            ev_done_q    <= ev_done_d;
            ev_line_q    <= ev_line_d;
            ev_frame_q   <= ev_frame_d;
            frame_done_q <= ev_done_q;
            err_line_q   <= ev_line_q;
            err_frame_q  <= ev_frame_q;
            if (ev_done_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (DOUBLE_BUF != 0) begin
                    wr_bank_q <= ~wr_bank_q;
                    rd_bank_q <= ~rd_bank_q;
                end
            end
        end
    end

    // Frame store write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= pix_word;
        end
    end

    assign rd_in_range = int'(rd_addr_i) < DEPTH;
    assign rd_idx      = MW'(int'(rd_bank_q) * DEPTH + int'(rd_addr_i));

    // Registered read from the display bank; out-of-frame addresses read 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= 32'd0;
        end else begin
            rd_data_q <= rd_in_range ? mem_q[rd_idx] : 32'd0;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_line_o   = err_line_q;
    assign err_frame_o  = err_frame_q;
    assign wr_bank_o    = wr_bank_q;
    assign rd_bank_o    = rd_bank_q;

endmodule

// File: tb/tb_vga_frame_grabber.sv
// tb_vga_frame_grabber: directed stimulus for a 4x3 screen, shared by five
// instances (RGB888, RGB565, GRAY8, single-bank RGB888, active-low vsync).
module tb_vga_frame_grabber;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    // instance index: 0 = rgb888, 1 = rgb565, 2 = gray8, 3 = single bank, 4 = vs active-low
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vs  = 1'b0;
    logic          vs_n;
    logic          hs  = 1'b0;
    logic          de  = 1'b0;
    logic [7:0]    dr  = 8'd0;
    logic [7:0]    dg  = 8'd0;
    logic [7:0]    db  = 8'd0;
    logic [AW-1:0] rd_addr = '0;

    logic [31:0] rdd [5];
    logic [15:0] fc  [5];
    logic        fd  [5];
    logic        el  [5];
    logic        ef  [5];
    logic        wb  [5];
    logic        rb  [5];

    int n_done   [5];
    int n_eline  [5];
    int n_eframe [5];
    int total = 0;
    int bad   = 0;
    int ef_before;

    assign vs_n = ~vs;

    always #5 clk = ~clk;

    vga_frame_grabber #(.SCR_W(W), .SCR_H(H), .PIX_FMT(0), .VS_POL(1), .DOUBLE_BUF(1)) u_dut (
        .clk(clk), .rst(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_r_i(dr), .data_g_i(dg), .data_b_i(db), .rd_addr_i(rd_addr),
        .rd_data_o(rdd[0]), .frame_done_o(fd[0]), .frame_cnt_o(fc[0]),
        .err_line_o(el[0]), .err_frame_o(ef[0]), .wr_bank_o(wb[0]), .rd_bank_o(rb[0]));

    vga_frame_grabber #(.SCR_W(W), .SCR_H(H), .PIX_FMT(1), .VS_POL(1), .DOUBLE_BUF(1)) u_565 (
        .clk(clk), .rst(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_r_i(dr), .data_g_i(dg), .data_b_i(db), .rd_addr_i(rd_addr),
        .rd_data_o(rdd[1]), .frame_done_o(fd[1]), .frame_cnt_o(fc[1]),
        .err_line_o(el[1]), .err_frame_o(ef[1]), .wr_bank_o(wb[1]), .rd_bank_o(rb[1]));

    vga_frame_grabber #(.SCR_W(W), .SCR_H(H), .PIX_FMT(2), .VS_POL(1), .DOUBLE_BUF(1)) u_gray (
        .clk(clk), .rst(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_r_i(dr), .data_g_i(dg), .data_b_i(db), .rd_addr_i(rd_addr),
        .rd_data_o(rdd[2]), .frame_done_o(fd[2]), .frame_cnt_o(fc[2]),
        .err_line_o(el[2]), .err_frame_o(ef[2]), .wr_bank_o(wb[2]), .rd_bank_o(rb[2]));

    vga_frame_grabber #(.SCR_W(W), .SCR_H(H), .PIX_FMT(0), .VS_POL(1), .DOUBLE_BUF(0)) u_sb (
        .clk(clk), .rst(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
        .data_r_i(dr), .data_g_i(dg), .data_b_i(db), .rd_addr_i(rd_addr),
        .rd_data_o(rdd[3]), .frame_done_o(fd[3]), .frame_cnt_o(fc[3]),
        .err_line_o(el[3]), .err_frame_o(ef[3]), .wr_bank_o(wb[3]), .rd_bank_o(rb[3]));

    vga_frame_grabber #(.SCR_W(W), .SCR_H(H), .PIX_FMT(0), .VS_POL(0), .DOUBLE_BUF(1)) u_vsn (
        .clk(clk), .rst(rst), .vs_i(vs_n), .hs_i(hs), .de_i(de),
        .data_r_i(dr), .data_g_i(dg), .data_b_i(db), .rd_addr_i(rd_addr),
        .rd_data_o(rdd[4]), .frame_done_o(fd[4]), .frame_cnt_o(fc[4]),
        .err_line_o(el[4]), .err_frame_o(ef[4]), .wr_bank_o(wb[4]), .rd_bank_o(rb[4]));

    // pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (fd[k]) n_done[k]++;
            if (el[k]) n_eline[k]++;
            if (ef[k]) n_eframe[k]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        de = 1'b0;
        tick(n);
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        de = 1'b1; dr = r; dg = g; db = b;
        tick(1);
    endtask

    task automatic line_px(input int n, input logic [23:0] base);
        logic [23:0] p;
        for (int i = 0; i < n; i++) begin
            p = base + 24'(i);
            pix(p[23:16], p[15:8], p[7:0]);
        end
        gap(2);
    endtask

    task automatic vsync();
        de = 1'b0;
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        tick(2);
    endtask

    task automatic set_addr(input int a);
        rd_addr = AW'(a);
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tick(3);
        chk("rst_cnt", 32'(fc[0]), 32'd0);
        chk("rst_rdata", rdd[0], 32'd0);
        chk("rst_wbank", 32'(wb[0]), 32'd0);
        chk("rst_rbank", 32'(rb[0]), 32'd1);
        chk("rst_rbank_sb", 32'(rb[3]), 32'd0);
        chk("rst_pulses", {29'd0, fd[0], el[0], ef[0]}, 32'd0);
        rst = 1'b1;
        gap(2);

        // good RGB888 frame into bank 0
        vsync();
        for (int l = 0; l < H; l++) line_px(W, 24'h010203 + 24'(4 * l));
        gap(3);
        chk("f1_done", 32'(n_done[0]), 32'd1);
        chk("f1_cnt", 32'(fc[0]), 32'd1);
        chk("f1_wbank", 32'(wb[0]), 32'd1);
        chk("f1_rbank", 32'(rb[0]), 32'd0);
        chk("f1_eline", 32'(n_eline[0]), 32'd0);
        chk("f1_eframe", 32'(n_eframe[0]), 32'd0);
        chk("f1_sb_banks", {30'd0, wb[3], rb[3]}, 32'd0);
        set_addr(5);
        chk("f1_rd5", rdd[0], 32'h00010208);
        chk("f1_sb_rd5", rdd[3], 32'h00010208);
        set_addr(11);
        chk("f1_rd11", rdd[0], 32'h0001020E);
        set_addr(12);
        chk("f1_rd12_oob", rdd[0], 32'd0);

        // frame with a short line, then a vsync before completion
        vsync();
        line_px(W, 24'h100000);
        line_px(3, 24'h200000);
        line_px(W, 24'h300000);
        gap(3);
        chk("f2_eline", 32'(n_eline[0]), 32'd1);
        chk("f2_no_done", 32'(n_done[0]), 32'd1);
        vsync();
        chk("f2_eframe", 32'(n_eframe[0]), 32'd1);
        chk("f2_cnt", 32'(fc[0]), 32'd1);
        chk("f2_banks", {30'd0, wb[0], rb[0]}, 32'h2);
        set_addr(5);
        chk("f2_disp_kept", rdd[0], 32'h00010208);
        chk("f2_sb_rd5", rdd[3], 32'h00200001);

        // format samples on line 0, plus one overflow line after completion
        pix(8'hF8, 8'hFC, 8'hF8);
        pix(8'h80, 8'h00, 8'h00);
        pix(8'hFF, 8'hFF, 8'hFF);
        pix(8'h64, 8'h00, 8'h00);
        gap(2);
        line_px(W, 24'h400000);
        line_px(W, 24'h500000);
        line_px(W, 24'h600000);
        gap(3);
        chk("f3_done", 32'(n_done[0]), 32'd2);
        chk("f3_cnt", 32'(fc[0]), 32'd2);
        chk("f3_banks", {30'd0, wb[0], rb[0]}, 32'h1);
        chk("f3_eline", 32'(n_eline[0]), 32'd2);
        chk("f3_sb_cnt", 32'(fc[3]), 32'd2);
        set_addr(0);
        chk("rgb888_a0", rdd[0], 32'h00F8FCF8);
        chk("rgb565_a0", rdd[1], 32'h00FFFFFF);
        chk("gray_a0", rdd[2], 32'h00FAFAFA);
        chk("sb_overflow_nowr", rdd[3], 32'h00F8FCF8);
        set_addr(1);
        chk("rgb565_a1", rdd[1], 32'h00840000);
        set_addr(2);
        chk("rgb565_a2", rdd[1], 32'h00FFFFFF);
        chk("gray_a2", rdd[2], 32'h00FFFFFF);
        set_addr(3);
        chk("rgb565_a3", rdd[1], 32'h00630000);
        chk("gray_a3", rdd[2], 32'h001E1E1E);
        set_addr(8);
        chk("rgb888_a8", rdd[0], 32'h00500000);

        // active-low vsync instance: mid-frame reset then a clean frame
        chk("vsn_cnt", 32'(fc[4]), 32'd2);
        vsync();
        line_px(W, 24'h700000);
        ef_before = n_eframe[4];
        rst = 1'b0;
        #1;
        chk("vsn_rst_cnt", 32'(fc[4]), 32'd0);
        chk("vsn_rst_rdata", rdd[4], 32'd0);
        chk("vsn_rst_banks", {30'd0, wb[4], rb[4]}, 32'h1);
        chk("vsn_rst_pulses", {29'd0, fd[4], el[4], ef[4]}, 32'd0);
        tick(2);
        rst = 1'b1;
        gap(2);
        vsync();
        chk("vsn_no_eframe", 32'(n_eframe[4]), 32'(ef_before));
        for (int l = 0; l < H; l++) line_px(W, 24'h800000 + 24'(16 * l));
        gap(3);
        chk("vsn_cnt_after", 32'(fc[4]), 32'd1);
        chk("vsn_banks", {30'd0, wb[4], rb[4]}, 32'h2);
        set_addr(2);
        chk("vsn_rd2", rdd[4], 32'h00800002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
